uart_rx_fifo: RTL and testbench

Receive-side byte buffer for the UART path. It captures each completed byte from the UART receiver, indicated by a rising edge on the receiver's done level. It stores bytes in a circular FIFO and presents them first-word-fall-through to the SoC register/bus side. It also reports fill level, a sticky overrun flag, and an optional threshold interrupt.

---
 rtl/uart_rx_fifo_if.sv | 30 +++
 rtl/uart_rx_fifo.sv | 112 +++++++++++
 tb/tb_uart_rx_fifo.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bus-side and receiver-side signal bundle for uart_rx_fifo.
// slave  : the FIFO itself (samples i_*, drives o_*).
// master : receiver / register block / bench (drives i_*, samples o_*).
interface uart_rx_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            i_rx_done;
  logic [7:0]      i_rx_data;
  logic            i_rd_en;
  logic            i_flush;
  logic            i_clr_overrun;
  logic [7:0]      o_rd_data;
  logic            o_empty;
  logic            o_full;
  logic [CntW-1:0] o_count;
  logic            o_overrun;
  logic            o_irq;

  modport slave (
    input  i_rx_done, i_rx_data, i_rd_en, i_flush, i_clr_overrun,
    output o_rd_data, o_empty, o_full, o_count, o_overrun, o_irq
  );

  modport master (
    output i_rx_done, i_rx_data, i_rd_en, i_flush, i_clr_overrun,
    input  o_rd_data, o_empty, o_full, o_count, o_overrun, o_irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO, first-word-fall-through.
// Captures one byte per rising edge of the receiver's done level, buffers DEPTH
// bytes in a circular store, reports fill level and a sticky overrun flag.
// Optional threshold/overrun interrupt: define UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned THRESH = 8
) (
  input logic           clk,
  input logic           rst_n,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  // Elaboration-time parameter sanity.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
  end
  if (THRESH < 1 || THRESH > DEPTH) begin : g_bad_thresh
    $error("uart_rx_fifo: THRESH must be in 1..DEPTH");
  end

  logic [7:0]      mem [DEPTH];
  logic            done_q;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overrun_q, overrun_d;

  logic push, pop, empty, full, wr_en, ovr_set;

  // Push/pop qualification and next-state for pointers, count and overrun.
  always_comb begin
    push    = bus.i_rx_done & ~done_q;
    empty   = (count_q == '0);
    full    = (count_q == DepthCnt);
    pop     = bus.i_rd_en & ~empty;
    // A simultaneous pop frees the slot a push into a full FIFO needs.
    wr_en   = push & ~bus.i_flush & (~full | pop);
    // A push lost to flush is not an overrun.
    ovr_set = push & ~bus.i_flush & full & ~pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({wr_en, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end

    // Set beats clear.
    overrun_d = ovr_set | (overrun_q & ~bus.i_clr_overrun);
  end

  // Control state; stored bytes are discarded by reset via the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= bus.i_rx_done;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Byte storage, not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= bus.i_rx_data;
  end

`ifdef UART_RX_FIFO_IRQ_EN
  logic irq_q, irq_d;

  // Interrupt tracks next-cycle fill level and overrun.
  always_comb begin
    irq_d = (count_d >= CntW'(THRESH)) | overrun_d;
  end

  // Registered interrupt output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign bus.o_irq = irq_q;
`else
  assign bus.o_irq = 1'b0;
`endif

  assign bus.o_rd_data = mem[rd_ptr_q];
  assign bus.o_empty   = empty;
  assign bus.o_full    = full;
  assign bus.o_count   = count_q;
  assign bus.o_overrun = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed test-plan steps followed by
// random traffic, all checked against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned THRESH = 8;

  logic clk = 1'b0;
  logic rst_n;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .THRESH(THRESH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [7:0] fifo_q[$];
  logic       m_ovr;
  logic       m_prev_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    m_ovr       = 1'b0;
    m_prev_done = 1'b0;
  endtask

  // One clock edge of the FIFO's behaviour, from the rules directly.
  task automatic model_edge(input logic done, input logic [7:0] data, input logic rd,
                            input logic fl, input logic clr);
    logic push, pop, set;
    push = done && !m_prev_done;
    pop  = rd && (fifo_q.size() > 0);
    set  = 1'b0;
    if (fl) begin
      fifo_q.delete();
    end else begin
      if (push && fifo_q.size() == DEPTH && !pop) set = 1'b1;
      if (pop) void'(fifo_q.pop_front());
      if (push && !set) fifo_q.push_back(data);
    end
    if (set) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    m_prev_done = done;
  endtask

  task automatic check_all(input string tag);
    logic exp_irq;
`ifdef UART_RX_FIFO_IRQ_EN
    exp_irq = (fifo_q.size() >= THRESH) || m_ovr;
`else
    exp_irq = 1'b0;
`endif
    chk({tag, "_count"}, 32'(bus.o_count), 32'(fifo_q.size()));
    chk({tag, "_empty"}, 32'(bus.o_empty), 32'(fifo_q.size() == 0));
    chk({tag, "_full"}, 32'(bus.o_full), 32'(fifo_q.size() == DEPTH));
    chk({tag, "_ovr"}, 32'(bus.o_overrun), 32'(m_ovr));
    chk({tag, "_irq"}, 32'(bus.o_irq), 32'(exp_irq));
    if (fifo_q.size() > 0) chk({tag, "_data"}, 32'(bus.o_rd_data), 32'(fifo_q[0]));
  endtask

  task automatic step(input string tag, input logic done, input logic [7:0] data,
                      input logic rd, input logic fl, input logic clr);
    @(negedge clk);
    bus.i_rx_done     = done;
    bus.i_rx_data     = data;
    bus.i_rd_en       = rd;
    bus.i_flush       = fl;
    bus.i_clr_overrun = clr;
    @(posedge clk);
    model_edge(done, data, rd, fl, clr);
    #1;
    check_all(tag);
  endtask

  task automatic pulse(input string tag, input logic [7:0] data);
    step(tag, 1'b1, data, 1'b0, 1'b0, 1'b0);
    step(tag, 1'b0, data, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop1(input string tag);
    step(tag, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 1; i++) pop1(tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(bus.o_count), 32'd0);
    chk({tag, "_empty"}, 32'(bus.o_empty), 32'd1);
    chk({tag, "_full"}, 32'(bus.o_full), 32'd0);
    chk({tag, "_ovr"}, 32'(bus.o_overrun), 32'd0);
    chk({tag, "_irq"}, 32'(bus.o_irq), 32'd0);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.i_rx_done     = 1'b0;
    bus.i_rx_data     = 8'h00;
    bus.i_rd_en       = 1'b0;
    bus.i_flush       = 1'b0;
    bus.i_clr_overrun = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic FWFT ordering.
    pulse("basic_push", 8'h41);
    chk("basic_cnt1", 32'(bus.o_count), 32'd1);
    pulse("basic_push", 8'h42);
    chk("basic_cnt2", 32'(bus.o_count), 32'd2);
    pulse("basic_push", 8'h43);
    chk("basic_cnt3", 32'(bus.o_count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("basic_head", 32'(bus.o_rd_data), 32'h41 + 32'(i));
      pop1("basic_pop");
    end
    chk("basic_empty", 32'(bus.o_empty), 32'd1);
    pop1("pop_empty");

    // Done held high for 20 clocks pushes once.
    for (int i = 0; i < 20; i++) step("held", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    step("held", 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    chk("held_cnt", 32'(bus.o_count), 32'd1);
    drain("held_drain");

    // Fill past full.
    for (int i = 0; i < 17; i++) pulse("ovf_push", 8'(i));
    chk("ovf_full", 32'(bus.o_full), 32'd1);
    chk("ovf_flag", 32'(bus.o_overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_head", 32'(bus.o_rd_data), 32'(i));
      pop1("ovf_pop");
    end
    step("clr_ovr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_flag", 32'(bus.o_overrun), 32'd0);

    // Push and pop together while full, then drain across the wrap.
    for (int i = 0; i < 16; i++) pulse("wrap_fill", 8'(8'h80 + i));
    step("wrap_both", 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    chk("wrap_cnt", 32'(bus.o_count), 32'd16);
    chk("wrap_ovr", 32'(bus.o_overrun), 32'd0);
    step("wrap_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) pop1("wrap_pop");
    chk("wrap_last", 32'(bus.o_rd_data), 32'hAA);
    pop1("wrap_pop");

    // Flush beats a concurrent push; overrun preserved (set it first).
    for (int i = 0; i < 17; i++) pulse("fl_ovf", 8'(i));
    drain("fl_drain");
    for (int i = 0; i < 5; i++) pulse("fl_fill", 8'(8'h30 + i));
    step("flush", 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("flush_cnt", 32'(bus.o_count), 32'd0);
    chk("flush_empty", 32'(bus.o_empty), 32'd1);
    chk("flush_ovr", 32'(bus.o_overrun), 32'd1);
    step("flush_lo", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Threshold interrupt (expected value depends on build).
    for (int i = 0; i < 7; i++) pulse("irq_push", 8'(8'h60 + i));
    pulse("irq_push8", 8'h67);
    pop1("irq_pop");
    drain("irq_drain");

    // Random traffic in phases of different pop pressure.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 600; i++) begin
        logic rd;
        rd = (ph == 0) ? ($urandom_range(0, 7) == 0) :
             (ph == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) != 0);
        step("rand", 1'($urandom_range(0, 1)), 8'($urandom), rd,
             $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
      end
    end

    // Asynchronous reset mid-burst, then done high at release.
    for (int i = 0; i < 6; i++) pulse("burst", 8'($urandom));
    step("burst", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    model_reset();
    bus.i_rx_done = 1'b1;
    bus.i_rx_data = 8'h77;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_edge(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    #1;
    check_all("rel_push");
    chk("rel_cnt", 32'(bus.o_count), 32'd1);
    step("rel_hold", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("rel_once", 32'(bus.o_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
